// File: rtl/riscv_data_bus.sv
// riscv_data_bus
//   Single-master, multi-slave data bus bridge. The master request is decoded
//   on a 4-bit slave-select field of the address. The transaction fields are
//   latched and presented to the selected slave until that slave reports ready
//   or a wait timeout expires. The master then gets a one-cycle completion
//   pulse, with registered read data and an error flag.
//
// Parameters
//   N_SLAVES : number of slave channels (1..16)
//   SEL_LSB  : LSB of the slave-select field addr[SEL_LSB+3:SEL_LSB]
//   TIMEOUT  : maximum WAIT cycles before an error response (2..255)
//   ERR_DATA : read data returned with an error response
//
// Ports
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-low reset
//   m_req_i    : master request, held until m_ready_o
//   m_we_i     : master write enable
//   m_be_i     : master byte enables
//   m_addr_i   : master address
//   m_wd_i     : master write data
//   m_rd_o     : registered read data
//   m_ready_o  : one-cycle transaction-complete pulse
//   m_err_o    : error flag, valid with m_ready_o
//   s_req_o    : one-hot slave request (asserted only while waiting)
//   s_we_o     : latched write enable, shared by all slaves
//   s_be_o     : latched byte enables, shared by all slaves
//   s_addr_o   : latched address, shared by all slaves
//   s_wd_o     : latched write data, shared by all slaves
//   s_rd_i     : slave read data, slave k at [32k+31:32k]
//   s_ready_i  : slave ready, one bit per slave
//   err_cnt_o  : saturating count of error responses

module riscv_data_bus #(
    parameter int unsigned N_SLAVES = 4,
    parameter int unsigned SEL_LSB  = 28,
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    m_req_i,
    input  logic                    m_we_i,
    input  logic [3:0]              m_be_i,
    input  logic [31:0]             m_addr_i,
    input  logic [31:0]             m_wd_i,
    output logic [31:0]             m_rd_o,
    output logic                    m_ready_o,
    output logic                    m_err_o,
    output logic [N_SLAVES-1:0]     s_req_o,
    output logic                    s_we_o,
    output logic [3:0]              s_be_o,
    output logic [31:0]             s_addr_o,
    output logic [31:0]             s_wd_o,
    input  logic [N_SLAVES*32-1:0]  s_rd_i,
    input  logic [N_SLAVES-1:0]     s_ready_i,
    output logic [7:0]              err_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_we;
    logic [3:0]          r_be;
    logic [31:0]         r_addr;
    logic [31:0]         r_wd;
    logic [3:0]          r_sel;
    logic [7:0]          r_wcnt;
    logic [31:0]         r_rd;
    logic                r_err;
    logic [7:0]          r_err_cnt;

    logic [3:0]          w_in_sel;
    logic                w_in_mapped;
    logic                w_sel_ready;
    logic [31:0]         w_sel_rd;
    logic [N_SLAVES-1:0] w_sreq;
    logic                w_timeout;

    // Select field of the incoming address, decoded before it is latched.
    assign w_in_sel    = m_addr_i[SEL_LSB+3:SEL_LSB];
    assign w_in_mapped = (32'(w_in_sel) < N_SLAVES);

    assign w_timeout   = (r_wcnt == 8'(TIMEOUT - 1));

    // Route only the selected slave's ready/data; other slaves are ignored.
    // The loop compare avoids indexing past N_SLAVES for unmapped selects.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_rd    = '0;
        w_sreq      = '0;
        for (int unsigned k = 0; k < N_SLAVES; k++) begin
            if (32'(r_sel) == k) begin
                w_sel_ready = s_ready_i[k];
                w_sel_rd    = s_rd_i[32*k +: 32];
                w_sreq[k]   = (r_state == ST_WAIT);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m_req_i) begin
                    w_state_nxt = w_in_mapped ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (w_sel_ready || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_we      <= 1'b0;
            r_be      <= '0;
            r_addr    <= '0;
            r_wd      <= '0;
            r_sel     <= '0;
            r_wcnt    <= '0;
            r_rd      <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m_req_i) begin
                        r_we   <= m_we_i;
                        r_be   <= m_be_i;
                        r_addr <= m_addr_i;
                        r_wd   <= m_wd_i;
                        r_sel  <= w_in_sel;
                        r_wcnt <= '0;
                        if (!w_in_mapped) begin
                            r_rd  <= ERR_DATA;
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    // Ready takes priority over a simultaneous timeout.
                    if (w_sel_ready) begin
                        r_rd  <= w_sel_rd;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_rd  <= ERR_DATA;
                        r_err <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (r_err && (r_err_cnt != 8'hFF)) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign s_req_o   = w_sreq;
    assign s_we_o    = r_we;
    assign s_be_o    = r_be;
    assign s_addr_o  = r_addr;
    assign s_wd_o    = r_wd;
    assign m_rd_o    = r_rd;
    assign m_err_o   = r_err;
    assign m_ready_o = (r_state == ST_RESP);
    assign err_cnt_o = r_err_cnt;

endmodule
